// File: rtl/formant_sched_pkg.sv
// Shared state types and fixed timing constants for the formant frame scheduler.
package formant_sched_pkg;

  typedef enum logic [1:0] {C_IDLE, C_FILL, C_DROP} cap_state_t;
  typedef enum logic [1:0] {E_IDLE, E_REPLAY, E_WAIT, E_RECOVER} eng_state_t;

  localparam int RECOVER_CYCLES = 4;
  localparam int BUF_LATENCY    = 2;

endpackage

// File: rtl/formant_sched_frame_buffer.sv
// Single-frame bin store: block RAM model (port A write, port B read, output register)
// plus the read-valid pipeline that aligns the strobe with the registered read data.
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int    RAM_WIDTH       = 32,
  parameter int    RAM_DEPTH       = 160,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic                         clka,
  input  logic                         ena,
  input  logic                         wea,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         enb,
  input  logic                         rstb,
  input  logic                         regceb,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_b;

  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dina;
    if (enb) ram_b <= mem[addrb];
  end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_reg
      assign doutb = ram_b;
    end else begin : g_reg
      always_ff @(posedge clka) begin
        if (rstb) doutb <= '0;
        else if (regceb) doutb <= ram_b;
      end
    end
  endgenerate

endmodule

module frame_buffer
  import formant_sched_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  input  logic                 wr_en,
  input  logic [$clog2(I)-1:0] wr_addr,
  input  logic [BIT_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [$clog2(I)-1:0] rd_addr,
  output logic [BIT_WIDTH-1:0] rd_data,
  output logic                 rd_valid
);

  logic [BUF_LATENCY-1:0] rd_pipe;

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) rd_pipe <= '0;
    else rd_pipe <= {rd_pipe[BUF_LATENCY-2:0], rd_en};
  end

  assign rd_valid = rd_pipe[BUF_LATENCY-1];

  // Output register only advances on real reads so it stays 0 after reset.
  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH      (BIT_WIDTH),
    .RAM_DEPTH      (I),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE")
  ) u_ram (
    .clka  (clk_in),
    .ena   (wr_en),
    .wea   (wr_en),
    .addra (wr_addr),
    .dina  (wr_data),
    .enb   (rd_en),
    .rstb  (~rst_in_n),
    .regceb(rd_pipe[0]),
    .addrb (rd_addr),
    .doutb (rd_data)
  );

endmodule

// File: rtl/formant_sched.sv
// Captures FFT magnitude frames into a one-frame buffer and replays them to the formant engine.
// Define FORMANT_SCHED_LATENCY_EN to add the eng_latency result-latency output.
module formant_sched
  import formant_sched_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int FORMANTS  = 5,
  parameter int TIMEOUT   = 1000000,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                clk_in,
  input  logic                                rst_in_n,
  input  logic                                s_valid,
  input  logic [BIT_WIDTH-1:0]                s_data,
  output logic                                eng_rst,
  output logic                                eng_fft_valid,
  output logic [BIT_WIDTH-1:0]                eng_fft_data,
  input  logic                                eng_formant_valid,
  input  logic [FORMANTS-1:0][BIT_WIDTH-1:0]  eng_formant_freq,
  output logic                                formant_valid,
  output logic [FORMANTS-1:0][BIT_WIDTH-1:0]  formant_freq,
  output logic                                frame_dropped,
  output logic                                timeout,
`ifdef FORMANT_SCHED_LATENCY_EN
  output logic [31:0]                         eng_latency,
`endif
  output logic [CNT_WIDTH-1:0]                frames_done,
  output logic [CNT_WIDTH-1:0]                frames_lost
);

  localparam int AW = $clog2(I);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RECOVER_CYCLES);

  cap_state_t    cap_state;
  eng_state_t    eng_state;
  logic          full, full_set, full_clr, drop_now;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, buf_wr_addr, rd_addr, beat_cnt;
  logic [WW-1:0] wd_cnt;
  logic [RW-1:0] rec_cnt;

  assign wr_en       = s_valid && ((cap_state == C_IDLE && !full) || cap_state == C_FILL);
  assign buf_wr_addr = (cap_state == C_FILL) ? wr_addr : '0;
  assign full_set    = cap_state == C_FILL && s_valid && wr_addr == AW'(I - 1);
  assign full_clr    = eng_state == E_REPLAY && eng_fft_valid && beat_cnt == AW'(I - 1);
  assign drop_now    = !s_valid && (cap_state == C_FILL || cap_state == C_DROP);

  frame_buffer #(.BIT_WIDTH(BIT_WIDTH), .I(I)) u_buf (
    .clk_in  (clk_in),
    .rst_in_n(rst_in_n),
    .wr_en   (wr_en),
    .wr_addr (buf_wr_addr),
    .wr_data (s_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (eng_fft_data),
    .rd_valid(eng_fft_valid)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) full <= 1'b0;
    else if (full_set) full <= 1'b1;
    else if (full_clr) full <= 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      cap_state     <= C_IDLE;
      wr_addr       <= '0;
      frame_dropped <= 1'b0;
      frames_lost   <= '0;
    end else begin
      frame_dropped <= drop_now;
      if (drop_now && frames_lost != '1) frames_lost <= frames_lost + 1'b1;
      case (cap_state)
        C_IDLE: if (s_valid) begin
          wr_addr   <= AW'(1);
          cap_state <= full ? C_DROP : C_FILL;
        end
        C_FILL: begin
          if (!s_valid || wr_addr == AW'(I - 1)) cap_state <= C_IDLE;
          else wr_addr <= wr_addr + 1'b1;
        end
        C_DROP: if (!s_valid) cap_state <= C_IDLE;
        default: cap_state <= C_IDLE;
      endcase
    end
  end

  // wd_cnt equals the number of cycles elapsed since the first replayed beat.
  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      eng_state     <= E_IDLE;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      beat_cnt      <= '0;
      wd_cnt        <= '0;
      rec_cnt       <= '0;
      eng_rst       <= 1'b0;
      timeout       <= 1'b0;
      formant_valid <= 1'b0;
      formant_freq  <= '0;
      frames_done   <= '0;
    end else begin
      timeout       <= 1'b0;
      formant_valid <= 1'b0;
      case (eng_state)
        E_IDLE: if (full) begin
          eng_state <= E_REPLAY;
          rd_en     <= 1'b1;
          rd_addr   <= '0;
          beat_cnt  <= '0;
          wd_cnt    <= '0;
        end
        E_REPLAY: begin
          if (rd_en) begin
            if (rd_addr == AW'(I - 1)) rd_en <= 1'b0;
            else rd_addr <= rd_addr + 1'b1;
          end
          if (eng_fft_valid) begin
            wd_cnt   <= wd_cnt + 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == AW'(I - 1)) eng_state <= E_WAIT;
          end
        end
        E_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (eng_formant_valid) begin
            formant_freq  <= eng_formant_freq;
            formant_valid <= 1'b1;
            if (frames_done != '1) frames_done <= frames_done + 1'b1;
            eng_state <= E_IDLE;
          end else if (wd_cnt >= WW'(TIMEOUT - 1)) begin
            timeout   <= 1'b1;
            eng_rst   <= 1'b1;
            rec_cnt   <= '0;
            eng_state <= E_RECOVER;
          end
        end
        E_RECOVER: begin
          if (rec_cnt == RW'(RECOVER_CYCLES - 1)) begin
            eng_rst   <= 1'b0;
            eng_state <= E_IDLE;
          end else begin
            rec_cnt <= rec_cnt + 1'b1;
          end
        end
        default: eng_state <= E_IDLE;
      endcase
    end
  end

`ifdef FORMANT_SCHED_LATENCY_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in_n) eng_latency <= '0;
    else if (eng_state == E_WAIT && eng_formant_valid) eng_latency <= 32'(wd_cnt);
  end
`endif

endmodule

// File: tb/tb_formant_sched.sv
// Directed bench for formant_sched: capture/replay, drop, short frame, watchdog, reset.
module tb_formant_sched;
  localparam int BW = 32;
  localparam int NI = 160;
  localparam int NF = 5;
  localparam int TO = 1000;
  localparam int CW = 16;

  logic                     clk_in = 1'b0;
  logic                     rst_in_n = 1'b0;
  logic                     s_valid = 1'b0;
  logic [BW-1:0]            s_data = '0;
  logic                     eng_rst;
  logic                     eng_fft_valid;
  logic [BW-1:0]            eng_fft_data;
  logic                     eng_formant_valid = 1'b0;
  logic [NF-1:0][BW-1:0]    eng_formant_freq = '0;
  logic                     formant_valid;
  logic [NF-1:0][BW-1:0]    formant_freq;
  logic                     frame_dropped;
  logic                     timeout;
`ifdef FORMANT_SCHED_LATENCY_EN
  logic [31:0]              eng_latency;
`endif
  logic [CW-1:0]            frames_done;
  logic [CW-1:0]            frames_lost;

  formant_sched #(.BIT_WIDTH(BW), .I(NI), .FORMANTS(NF), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk_in           (clk_in),
    .rst_in_n         (rst_in_n),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .eng_rst          (eng_rst),
    .eng_fft_valid    (eng_fft_valid),
    .eng_fft_data     (eng_fft_data),
    .eng_formant_valid(eng_formant_valid),
    .eng_formant_freq (eng_formant_freq),
    .formant_valid    (formant_valid),
    .formant_freq     (formant_freq),
    .frame_dropped    (frame_dropped),
    .timeout          (timeout),
`ifdef FORMANT_SCHED_LATENCY_EN
    .eng_latency      (eng_latency),
`endif
    .frames_done      (frames_done),
    .frames_lost      (frames_lost)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Observers sample mid-cycle and record events with their cycle number.
  int beats[$];
  int beat_cyc[$];
  int fv_cnt = 0, drop_cnt = 0, to_cnt = 0, rst_cnt = 0, to_cyc = -1, rst_last = -1;
  always @(negedge clk_in) begin
    if (eng_fft_valid) begin
      beats.push_back(int'(eng_fft_data));
      beat_cyc.push_back(cyc);
    end
    if (formant_valid) fv_cnt++;
    if (frame_dropped) drop_cnt++;
    if (timeout) begin to_cnt++; to_cyc = cyc; end
    if (eng_rst) begin rst_cnt++; rst_last = cyc; end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [NF*BW-1:0] obs, input logic [NF*BW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NF*BW-1:0] mkv(input int base);
    logic [NF*BW-1:0] v;
    v = '0;
    for (int i = 0; i < NF; i++) v[i*BW +: BW] = BW'(base + i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input int n, input int base, input int step, output int last_cyc);
    last_cyc = cyc;
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = BW'(base + k * step);
      last_cyc = cyc;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string tag);
    int budget;
    budget = 3000;
    while (beats.size() < target && budget > 0) begin
      tick();
      budget--;
    end
    chk(tag, int'(beats.size() >= target), 1);
  endtask

  task automatic chk_frame(input int start, input int base, input int step, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < NI; k++)
      if (beats.size() <= start + k || beats[start + k] != base + k * step) bad++;
    chk({tag, " data"}, bad, 0);
    if (beats.size() >= start + NI)
      chk({tag, " contiguous"}, beat_cyc[start + NI - 1] - beat_cyc[start], NI - 1);
  endtask

  task automatic respond_at(input int target, input logic [NF*BW-1:0] vals);
    while (cyc < target) tick();
    eng_formant_valid = 1'b1;
    eng_formant_freq  = vals;
    tick();
    eng_formant_valid = 1'b0;
    eng_formant_freq  = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench stalled");
  end

  initial begin
    int s, f, last, d0, t0, r0, fv0;

    // Reset state
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst eng_fft_valid", int'(eng_fft_valid), 0);
    chk("rst eng_fft_data", int'(eng_fft_data), 0);
    chk("rst eng_rst", int'(eng_rst), 0);
    chk("rst formant_valid", int'(formant_valid), 0);
    chk("rst frame_dropped", int'(frame_dropped), 0);
    chk("rst timeout", int'(timeout), 0);
    chk("rst frames_done", int'(frames_done), 0);
    chk("rst frames_lost", int'(frames_lost), 0);
    chk_vec("rst formant_freq", formant_freq, '0);
    tick();
    rst_in_n = 1'b1;
    repeat (3) tick();

    // Single frame, bins k*3, result 500 cycles after first beat
    s = beats.size();
    send_frame(NI, 0, 3, last);
    wait_beats(s + NI, "t1 beats arrive");
    f = beat_cyc[s];
    chk("t1 first beat latency", f - last, 4);
    chk_frame(s, 0, 3, "t1");
    fv0 = fv_cnt;
    respond_at(f + 500, mkv(100));
    @(negedge clk_in);
    chk("t1 formant_valid pulse", int'(formant_valid), 1);
    chk_vec("t1 formant_freq", formant_freq, mkv(100));
    tick(); tick();
    chk("t1 formant_valid count", fv_cnt - fv0, 1);
    chk("t1 frames_done", int'(frames_done), 1);
    chk("t1 beat count", beats.size() - s, NI);

    // Second frame during E_WAIT, third dropped, second replayed after result
    s = beats.size();
    d0 = drop_cnt;
    send_frame(NI, 1000, 1, last);
    wait_beats(s + NI, "t2 A beats arrive");
    f = beat_cyc[s];
    tick();
    send_frame(NI, 2000, 1, last);
    tick(); tick();
    send_frame(NI, 3000, 1, last);
    repeat (3) tick();
    chk("t2 drop pulses", drop_cnt - d0, 1);
    chk("t2 frames_lost", int'(frames_lost), 1);
    chk("t2 no replay while waiting", beats.size() - s, NI);
    respond_at(f + 600, mkv(200));
    wait_beats(s + 2 * NI, "t2 B beats arrive");
    chk("t2 B start after result", beat_cyc[s + NI] - (f + 600), 4);
    chk_frame(s + NI, 2000, 1, "t2 B");
    f = beat_cyc[s + NI];
    respond_at(f + 300, mkv(300));
    tick(); tick();
    chk("t2 frames_done", int'(frames_done), 3);
    chk("t2 total beats", beats.size() - s, 2 * NI);
    chk_vec("t2 formant_freq", formant_freq, mkv(300));

    // Short frame
    s = beats.size();
    d0 = drop_cnt;
    send_frame(100, 4000, 1, last);
    repeat (20) tick();
    chk("t3 short drop pulse", drop_cnt - d0, 1);
    chk("t3 frames_lost", int'(frames_lost), 2);
    chk("t3 no replay", beats.size() - s, 0);
    send_frame(NI, 5000, 1, last);
    wait_beats(s + NI, "t3 full frame beats");
    chk("t3 next frame latency", beat_cyc[s] - last, 4);
    chk_frame(s, 5000, 1, "t3");
    f = beat_cyc[s];
    respond_at(f + 200, mkv(400));
    tick(); tick();
    chk("t3 frames_done", int'(frames_done), 4);

    // Engine never responds
    s = beats.size();
    t0 = to_cnt; r0 = rst_cnt; fv0 = fv_cnt;
    send_frame(NI, 6000, 1, last);
    wait_beats(s + NI, "t4 beats arrive");
    f = beat_cyc[s];
    while (to_cnt == t0 && cyc < f + 1200) tick();
    chk("t4 timeout pulses", to_cnt - t0, 1);
    chk("t4 timeout cycle", to_cyc - f, TO);
    repeat (10) tick();
    chk("t4 eng_rst cycles", rst_cnt - r0, 4);
    chk("t4 eng_rst last cycle", rst_last - f, TO + 3);
    chk_vec("t4 formant_freq held", formant_freq, mkv(400));
    chk("t4 no result", fv_cnt - fv0, 0);
    chk("t4 frames_done held", int'(frames_done), 4);
    s = beats.size();
    send_frame(NI, 7000, 1, last);
    wait_beats(s + NI, "t4 recovery beats");
    chk_frame(s, 7000, 1, "t4 recovery");
    f = beat_cyc[s];
    respond_at(f + 100, mkv(500));
    tick(); tick();
    chk("t4 frames_done after recovery", int'(frames_done), 5);
    chk_vec("t4 formant_freq after recovery", formant_freq, mkv(500));

    // Result coincides with watchdog expiry
    s = beats.size();
    t0 = to_cnt; r0 = rst_cnt; fv0 = fv_cnt;
    send_frame(NI, 8000, 1, last);
    wait_beats(s + NI, "t5 beats arrive");
    f = beat_cyc[s];
    respond_at(f + TO - 1, mkv(600));
    repeat (20) tick();
    chk("t5 no timeout", to_cnt - t0, 0);
    chk("t5 no eng_rst", rst_cnt - r0, 0);
    chk("t5 result accepted", fv_cnt - fv0, 1);
    chk("t5 frames_done", int'(frames_done), 6);
    chk_vec("t5 formant_freq", formant_freq, mkv(600));

    // Reset during replay beat 80
    s = beats.size();
    send_frame(NI, 9000, 1, last);
    wait_beats(s + 1, "t6 replay starts");
    f = beat_cyc[s];
    while (cyc < f + 80) tick();
    rst_in_n = 1'b0;
    tick();
    @(negedge clk_in);
    chk("t6 eng_fft_valid", int'(eng_fft_valid), 0);
    chk("t6 eng_fft_data", int'(eng_fft_data), 0);
    chk("t6 frames_done", int'(frames_done), 0);
    chk("t6 frames_lost", int'(frames_lost), 0);
    chk_vec("t6 formant_freq", formant_freq, '0);
    tick();
    rst_in_n = 1'b1;
    repeat (200) tick();
    chk("t6 beats before reset only", beats.size() - s, 81);
    s = beats.size();
    send_frame(NI, 10000, 1, last);
    wait_beats(s + NI, "t6 next frame beats");
    chk("t6 next frame latency", beat_cyc[s] - last, 4);
    chk_frame(s, 10000, 1, "t6 next");
    f = beat_cyc[s];
    respond_at(f + 50, mkv(700));
    tick(); tick();
    chk("t6 frames_done after reset", int'(frames_done), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/formant_sched.md
Name: formant_sched

Overview:
Frame scheduler in front of the formant engine. Captures each FFT magnitude frame (I bins) into a single-frame buffer and replays it to the engine as a gap-free I-beat burst when the engine is idle. Drops frames that arrive while the buffer is occupied, watchdogs the engine, and latches its results. Sits between the FFT magnitude stage and the formant engine.

Parameters:
BIT_WIDTH, 32, bin and formant word width
I, 160, bins per frame
FORMANTS, 5, formant outputs per frame
TIMEOUT, 1000000, cycles allowed from first replay beat to engine result
CNT_WIDTH, 16, statistics counter width

Ports:
clk_in  in  1  clock
rst_in_n  in  1  synchronous active-low reset
s_valid  in  1  FFT bin valid; high for exactly I consecutive cycles per frame
s_data  in  BIT_WIDTH  FFT bin, bin 0 first
eng_rst  out  1  active-high engine reset (watchdog recovery)
eng_fft_valid  out  1  replay beat valid to engine
eng_fft_data  out  BIT_WIDTH  replay bin to engine
eng_formant_valid  in  1  engine result strobe
eng_formant_freq  in  BIT_WIDTH x FORMANTS  engine result array
formant_valid  out  1  one-cycle result pulse
formant_freq  out  BIT_WIDTH x FORMANTS  latched result
frame_dropped  out  1  one-cycle pulse per dropped or short frame
timeout  out  1  one-cycle pulse on watchdog expiry
frames_done  out  CNT_WIDTH  saturating count of results delivered
frames_lost  out  CNT_WIDTH  saturating count of frame_dropped pulses

Behaviour:
- Reset (rst_in_n low at clk edge):
  - All outputs 0; formant_freq all 0.
  - Counters 0; buffer marked empty; both FSMs in idle states.
  - Reset mid-frame or mid-replay abandons everything; buffer contents are not cleared, only the full flag.
- Capture FSM C_IDLE/C_FILL/C_DROP:
  - C_IDLE, s_valid=1 with buffer empty -> C_FILL; beat written at address 0.
  - C_IDLE, s_valid=1 with buffer full -> C_DROP.
  - C_FILL writes beat n at address n. On beat I-1: set full, go to C_IDLE.
  - s_valid low in C_FILL before I beats: short frame. Pulse frame_dropped, buffer stays empty, go to C_IDLE.
  - C_DROP consumes the burst and returns to C_IDLE when s_valid falls. frame_dropped pulses on the cycle s_valid falls.
- Engine FSM E_IDLE/E_REPLAY/E_WAIT/E_RECOVER:
  - E_IDLE with full=1 -> E_REPLAY. If full rises in a cycle, E_REPLAY is entered the next cycle.
  - E_REPLAY issues reads 0..I-1 on consecutive cycles. Buffer read latency is 2 cycles.
  - eng_fft_valid is high for exactly I consecutive cycles, starting 2 cycles after the first read, data in address order.
  - The full flag clears on the cycle the last beat is driven. Capture of a new frame may begin the following cycle.
  - After the last beat -> E_WAIT. The watchdog counter starts at 0 on the first driven beat.
  - E_WAIT, eng_formant_valid=1:
    - Register eng_formant_freq into formant_freq.
    - Pulse formant_valid on the next cycle, coincident with the new formant_freq.
    - frames_done increments (saturating at all-ones). Go to E_IDLE.
  - eng_formant_valid outside E_WAIT is ignored.
  - Watchdog reaches TIMEOUT-1 in E_WAIT without a result:
    - Pulse timeout; go to E_RECOVER.
    - eng_rst is high for exactly 4 cycles, then E_IDLE.
    - formant_freq is unchanged. A pending full buffer is then replayed normally.
  - If eng_formant_valid and watchdog expiry coincide, the result wins.
- frames_lost increments with every frame_dropped pulse and saturates.
- Widths: watchdog counter is $clog2(TIMEOUT+1) bits; address is $clog2(I) bits.

Optional Feature:
FORMANT_SCHED_LATENCY_EN: adds output eng_latency [31:0].
- Holds the cycle count from the first replayed beat to the accepted eng_formant_valid of the most recent successful frame.
- Updates in the same cycle formant_valid pulses; 0 after reset.
- Without the macro the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Package formant_sched_pkg:
  - cap_state_t {C_IDLE, C_FILL, C_DROP}
  - eng_state_t {E_IDLE, E_REPLAY, E_WAIT, E_RECOVER}
  - localparams RECOVER_CYCLES=4 and BUF_LATENCY=2
- Sub-module frame_buffer:
  - Wraps xilinx_true_dual_port_read_first_1_clock_ram (HIGH_PERFORMANCE, depth I, width BIT_WIDTH).
  - Port A writes, port B reads.
  - Includes a 2-stage read-valid shift register producing the data-valid strobe.

Test Plan:
- Single frame, bins 0..159 = value k*3; engine result after 500 cycles -> eng_fft_valid high 160 consecutive cycles carrying 0,3,..,477 in order; formant_valid pulses once; frames_done=1.
- Second frame arrives during E_WAIT, third arrives before the second is replayed -> second replayed immediately after the first result; third dropped; frame_dropped one pulse; frames_lost=1.
- Short frame, s_valid high 100 cycles then low -> frame_dropped pulse; no replay; buffer empty; next full frame captured and replayed.
- Engine never responds, TIMEOUT=1000 -> timeout pulse 1000 cycles after the first replay beat; eng_rst high exactly 4 cycles; formant_freq unchanged; next frame processed normally.
- eng_formant_valid asserted on the same cycle as watchdog expiry -> result accepted; no timeout; no eng_rst.
- rst_in_n low mid-replay (beat 80) -> all outputs 0 the next cycle; no further eng_fft_valid; the next frame is captured from address 0.
